rr_hold_arbiter: RTL and testbench

//   Round-robin arbiter sharing one resource among N_REQ level-sensitive requesters.

---
 rtl/rr_hold_arbiter_pkg.sv | 18 +
 rtl/rr_hold_arbiter_pick.sv | 36 +++
 rtl/rr_hold_arbiter.sv | 100 ++++++++++
 tb/tb_rr_hold_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_hold_arbiter_pkg.sv
// rtl/rr_hold_arbiter_pkg.sv - shared state encoding and parameter defaults for rr_hold_arbiter
package rr_hold_arbiter_pkg;

    localparam int N_REQ_DEF    = 4;
    localparam int MAX_HOLD_DEF = 8;
    localparam int CNT_W_DEF    = 4;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RECOVER = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_GRANT   = GRANT,
        ST_RECOVER = RECOVER
    } state_t;

endpackage

// File: rtl/rr_hold_arbiter_pick.sv
// rtl/rr_hold_arbiter_pick.sv - rr_pick: combinational rotate-priority encoder starting after last_id
module rr_pick
    import rr_hold_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_id,
    output logic [ID_W-1:0]  winner,
    output logic             valid
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester after last_id is kept.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            sum = {1'b0, last_id} + (ID_W+1)'(off);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_hold_arbiter.sv
// rtl/rr_hold_arbiter.sv - round-robin arbiter with registered one-hot grant and max hold revoke
module rr_hold_arbiter
    import rr_hold_arbiter_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  grant_id_o,
    output logic             busy_o,
    output logic             timeout_o
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [N_REQ-1:0] grant_d;
    logic [ID_W-1:0]  id_d;
    logic             timeout_d;
    logic [ID_W-1:0]  pick_id;
    logic             pick_valid;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req     (req),
        .last_id (last_q),
        .winner  (pick_id),
        .valid   (pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        last_d    = last_q;
        grant_d   = grant_o;
        id_d      = grant_id_o;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = N_REQ'(1) << pick_id;
                    id_d    = pick_id;
                    last_d  = pick_id;
                    hold_d  = CNT_W'(1);
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A voluntary release outranks the hold limit, so it never reports a timeout.
                if (!req[last_q]) begin
                    grant_d = '0;
                    state_d = ST_RECOVER;
                end else if (hold_q == CNT_W'(MAX_HOLD)) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_RECOVER;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            ST_RECOVER: begin
                grant_d = '0;
                hold_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            last_q     <= ID_W'(N_REQ - 1);
            grant_o    <= '0;
            grant_id_o <= '0;
            busy_o     <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            last_q     <= last_d;
            grant_o    <= grant_d;
            grant_id_o <= id_d;
            busy_o     <= (state_d == ST_GRANT);
            timeout_o  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb/tb_rr_hold_arbiter.sv - self-checking bench for rr_hold_arbiter (N_REQ=4, MAX_HOLD=8)
module tb_rr_hold_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

    logic         clock;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] grant_o;
    logic [1:0]   grant_id_o;
    logic         busy_o;
    logic         timeout_o;

    int checks_total  = 0;
    int checks_passed = 0;

    rr_hold_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MH),
        .CNT_W    (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .grant_o    (grant_o),
        .grant_id_o (grant_id_o),
        .busy_o     (busy_o),
        .timeout_o  (timeout_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input int act, input int exp);
        checks_total++;
        if (act == exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Owner-oriented model: who holds the resource, for how long, and whether a dead cycle is owed.
    int m_owner, m_held, m_last, m_id, m_to;
    bit m_dead;
    int w;
    int c;

    always @(posedge clock) begin
        if (reset) begin
            m_owner = -1;
            m_held  = 0;
            m_dead  = 1'b0;
            m_last  = N - 1;
            m_id    = 0;
            m_to    = 0;
        end else begin
            m_to = 0;
            if (m_owner >= 0) begin
                if (!req[m_owner]) begin
                    m_owner = -1;
                    m_dead  = 1'b1;
                end else if (m_held == MH) begin
                    m_owner = -1;
                    m_dead  = 1'b1;
                    m_to    = 1;
                end else begin
                    m_held++;
                end
            end else if (m_dead) begin
                m_dead = 1'b0;
            end else if (req != '0) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (w < 0 && req[c]) w = c;
                end
                m_owner = w;
                m_id    = w;
                m_last  = w;
                m_held  = 1;
            end
        end
        #1;
        check("model_grant", int'(grant_o), (m_owner >= 0) ? (1 << m_owner) : 0);
        check("model_id", int'(grant_id_o), m_id);
        check("model_busy", int'(busy_o), (m_owner >= 0) ? 1 : 0);
        check("model_timeout", int'(timeout_o), m_to);
        check("onehot", int'($countones(grant_o) <= 1), 1);
    end

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        step();
        step();
        check("rst_grant", int'(grant_o), 0);
        check("rst_id", int'(grant_id_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_timeout", int'(timeout_o), 0);

        // single requester holds for three samples then drops
        reset = 1'b0;
        req   = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            check("single_grant", int'(grant_o), 4'b0100);
            check("single_timeout", int'(timeout_o), 0);
        end
        check("single_id", int'(grant_id_o), 2);
        req = 4'b0000;
        step();
        check("single_release", int'(grant_o), 0);
        check("single_rel_timeout", int'(timeout_o), 0);
        check("single_rel_busy", int'(busy_o), 0);
        check("single_id_hold", int'(grant_id_o), 2);
        step();
        step();

        // all requesting: rotation with hold-limit revokes
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < MH; k++) begin
                step();
                check("rr_grant", int'(grant_o), 1 << (g % 4));
                check("rr_timeout_low", int'(timeout_o), 0);
            end
            if (g < 4) begin
                step();
                check("rr_gap1_grant", int'(grant_o), 0);
                check("rr_gap1_timeout", int'(timeout_o), 1);
                step();
                check("rr_gap2_grant", int'(grant_o), 0);
                check("rr_gap2_timeout", int'(timeout_o), 0);
            end
        end

        // wrap-around search after owner 1 releases
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 4'b0010;
        step();
        check("wrap_first", int'(grant_o), 4'b0010);
        check("wrap_first_id", int'(grant_id_o), 1);
        req = 4'b0000;
        step();
        check("wrap_release", int'(grant_o), 0);
        req = 4'b0011;
        step();
        check("wrap_dead", int'(grant_o), 0);
        step();
        check("wrap_next", int'(grant_o), 4'b0001);
        check("wrap_next_id", int'(grant_id_o), 0);

        // owner drops exactly when the hold limit is reached
        req = 4'b0001;
        for (int k = 0; k < MH - 1; k++) begin
            step();
            check("edge_hold", int'(grant_o), 4'b0001);
        end
        req = 4'b0000;
        step();
        check("edge_release", int'(grant_o), 0);
        check("edge_no_timeout", int'(timeout_o), 0);
        check("edge_busy", int'(busy_o), 0);
        step();

        // reset in the middle of a grant to requester 2
        req = 4'b0100;
        step();
        check("mid_grant", int'(grant_o), 4'b0100);
        check("mid_id", int'(grant_id_o), 2);
        step();
        reset = 1'b1;
        step();
        check("mid_rst_grant", int'(grant_o), 0);
        check("mid_rst_busy", int'(busy_o), 0);
        check("mid_rst_timeout", int'(timeout_o), 0);
        check("mid_rst_id", int'(grant_id_o), 0);
        reset = 1'b0;
        req   = 4'b1111;
        step();
        check("post_rst_grant", int'(grant_o), 4'b0001);
        check("post_rst_id", int'(grant_id_o), 0);

        req = 4'b0000;
        step();
        step();
        step();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", checks_passed, checks_total);
        $fatal(1);
    end

endmodule
